// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;

   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit synchronizer for active-low buttons; preset to 1 (released) on reset.
module sync_2ff
   import mult_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/shift_add_mult_n.sv
// WIDTH-generic signed/unsigned shift-add multiplier; product left in A:B, B reused for chaining.
module shift_add_mult_n
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             ClearA_LoadB,
   input  logic             SignedMode,
   input  logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_m;
   logic             r_x;
   logic             r_mode;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;

   logic             w_run_l;
   logic             w_load_l;
   logic [WIDTH:0]   w_a_ext;
   logic [WIDTH:0]   w_m_ext;
   logic             w_sub;
   logic [WIDTH:0]   w_sum;

   sync_2ff u_sync_run (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_d     (Run),
      .o_q     (w_run_l)
   );

   sync_2ff u_sync_load (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_d     (ClearA_LoadB),
      .o_q     (w_load_l)
   );

   // Signed mode subtracts on the final step: the multiplier MSB carries negative weight.
   assign w_a_ext = r_mode ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
   assign w_m_ext = r_mode ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
   assign w_sub   = r_mode && (r_cnt == LAST);
   assign w_sum   = w_sub ? (w_a_ext - w_m_ext) : (w_a_ext + w_m_ext);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= '0;
         r_x     <= 1'b0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (!w_load_l) begin
                  r_a <= '0;
                  r_x <= 1'b0;
                  r_b <= S;
               end else if (!w_run_l) begin
                  r_m     <= S;
                  r_mode  <= SignedMode;
                  r_a     <= '0;
                  r_x     <= 1'b0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ADD;
               end
            end
            ADD: begin
               if (r_b[0]) begin
                  {r_x, r_a} <= w_sum;
               end else begin
                  r_x <= r_mode & r_a[WIDTH-1];
               end
               r_state <= SHIFT;
            end
            SHIFT: begin
               r_a <= {r_x, r_a[WIDTH-1:1]};
               r_b <= {r_a[0], r_b[WIDTH-1:1]};
               if (!r_mode) begin
                  r_x <= 1'b0;
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state <= HOLD;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ADD;
               end
            end
            HOLD: begin
               // Wait for button release so one press yields exactly one multiply.
               if (w_run_l) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Aval = r_a;
   assign Bval = r_b;
   assign X    = r_x;
   assign Busy = r_busy;
   assign Done = r_done;

endmodule

// File: tb/tb_shift_add_mult_n.sv
// Scoreboard bench for shift_add_mult_n at WIDTH 8, 16 and 4.
module tb_shift_add_mult_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       run8_n, load8_n, sm8, x8, busy8, done8;
   logic [7:0] s8, a8, b8;
   logic        run16_n, load16_n, x16, busy16, done16;
   logic [15:0] s16, a16, b16;
   logic       run4_n, load4_n, x4, busy4, done4;
   logic [3:0] s4, a4, b4;

   int checks = 0;
   int errors = 0;
   int bc8, dc8, bc16, dc16, bc4, dc4;
   logic [16:0] exp_q[$];
   logic [16:0] sb_e;
   logic [7:0]  mb;

   shift_add_mult_n #(.WIDTH(8)) u_dut8 (
      .Clk(clk), .Reset(rst_n), .Run(run8_n), .ClearA_LoadB(load8_n), .SignedMode(sm8),
      .S(s8), .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
   );

   shift_add_mult_n #(.WIDTH(16)) u_dut16 (
      .Clk(clk), .Reset(rst_n), .Run(run16_n), .ClearA_LoadB(load16_n), .SignedMode(1'b1),
      .S(s16), .Aval(a16), .Bval(b16), .X(x16), .Busy(busy16), .Done(done16)
   );

   shift_add_mult_n #(.WIDTH(4)) u_dut4 (
      .Clk(clk), .Reset(rst_n), .Run(run4_n), .ClearA_LoadB(load4_n), .SignedMode(1'b1),
      .S(s4), .Aval(a4), .Bval(b4), .X(x4), .Busy(busy4), .Done(done4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (busy8)  bc8++;
      if (busy16) bc16++;
      if (busy4)  bc4++;
      if (done16) dc16++;
      if (done4)  dc4++;
      if (done8) begin
         dc8++;
         chk("sb_avail", exp_q.size(), 1);
         if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            chk("prod8", {x8, a8, b8}, sb_e);
            chk("busy8", bc8, 16);
         end
      end
   end

   task automatic load8(input logic [7:0] v);
      s8      = v;
      load8_n = 1'b0;
      @(posedge clk); #1;
      load8_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      mb = v;
      chk("load8_b", b8, v);
      chk("load8_a", a8, 8'h00);
   endtask

   task automatic run8(input logic [7:0] s, input logic sm, input bit mid_load);
      logic signed [15:0] sa, sb;
      logic [15:0]        ua, ub, p;
      int                 d0, n;
      sa = $signed(mb);
      sb = $signed(s);
      ua = mb;
      ub = s;
      p  = sm ? sa * sb : ua * ub;
      exp_q.push_back({sm ? p[15] : 1'b0, p});
      mb     = p[7:0];
      s8     = s;
      sm8    = sm;
      bc8    = 0;
      d0     = dc8;
      run8_n = 1'b0;
      n      = 0;
      while (dc8 == d0 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (mid_load && n == 8) begin
            load8_n = 1'b0;
            s8      = 8'h55;
         end else begin
            load8_n = 1'b1;
         end
      end
      load8_n = 1'b1;
      // Keep Run held to confirm HOLD does not retrigger.
      repeat (6) @(posedge clk);
      #1;
      chk("done_once", dc8 - d0, 1);
      run8_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst_n   = 1'b0;
      run8_n  = 1'b1; load8_n  = 1'b1; sm8 = 1'b1; s8 = '0;
      run16_n = 1'b1; load16_n = 1'b1; s16 = '0;
      run4_n  = 1'b1; load4_n  = 1'b1; s4 = '0;
      mb = '0;
      #12;
      chk("rst_a", a8, 0);
      chk("rst_b", b8, 0);
      chk("rst_x", x8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      load8(8'd7);
      run8(8'd59, 1'b1, 1'b0);
      chk("a_7x59", a8, 8'h01);
      chk("b_7x59", b8, 8'h9D);

      load8(8'd7);  run8(8'hC5, 1'b1, 1'b0);
      load8(8'hF9); run8(8'd59, 1'b1, 1'b0);
      load8(8'hF9); run8(8'hC5, 1'b1, 1'b0);
      chk("ab_m7xm59", {a8, b8}, 16'h019D);

      load8(8'hFE);
      for (int i = 0; i < 4; i++) run8(8'hFE, 1'b1, 1'b0);
      chk("chain", {a8, b8}, 16'hFFE0);

      load8(8'hFF); run8(8'hFF, 1'b0, 1'b0);
      chk("u255_x", x8, 0);
      chk("u255_ab", {a8, b8}, 16'hFE01);
      load8(8'h80); run8(8'h80, 1'b1, 1'b0);
      chk("m128sq", {a8, b8}, 16'h4000);

      load8(8'h0D); run8(8'h13, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         load8(8'($urandom));
         run8(8'($urandom), 1'($urandom), 1'(i == 2));
      end

      s16 = 16'd300; load16_n = 1'b0;
      @(posedge clk); #1;
      load16_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      s16 = 16'hFF38; bc16 = 0; n = dc16; run16_n = 1'b0;
      for (int i = 0; i < 100 && dc16 == n; i++) begin @(posedge clk); #1; end
      chk("done16", dc16 - n, 1);
      chk("prod16", {a16, b16}, 32'hFFFF15A0);
      chk("busy16", bc16, 32);
      run16_n = 1'b1;

      s4 = 4'h8; load4_n = 1'b0;
      @(posedge clk); #1;
      load4_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      bc4 = 0; n = dc4; run4_n = 1'b0;
      for (int i = 0; i < 100 && dc4 == n; i++) begin @(posedge clk); #1; end
      chk("done4", dc4 - n, 1);
      chk("prod4", {a4, b4}, 8'h40);
      chk("busy4", bc4, 8);
      run4_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      load8(8'h5A);
      s8 = 8'h33; sm8 = 1'b1; bc8 = 0; run8_n = 1'b0;
      for (int i = 0; i < 100 && bc8 < 5; i++) begin @(posedge clk); #1; end
      chk("busy_before_rst", busy8, 1);
      run8_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_a", a8, 0);
      chk("abort_b", b8, 0);
      chk("abort_x", x8, 0);
      chk("abort_busy", busy8, 0);
      #3 rst_n = 1'b1;
      mb = '0;
      @(posedge clk); #1;

      load8(8'd3);
      run8(8'd5, 1'b1, 1'b0);
      chk("after_rst", {a8, b8}, 16'h000F);

      chk("sb_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_add_mult_n.md
# shift_add_mult_n

Parametrised sequential shift-add multiplier: the WIDTH-generic successor of the 8-bit switch-driven multiplier. It performs a signed (two's-complement) or unsigned WIDTH×WIDTH multiply over 2·WIDTH clock cycles and leaves the 2·WIDTH-bit product in the A:B register pair. The product stays in B so the next run multiplies it again (chained multiply). It sits between the board switch/button inputs and the hex-display drivers in the lab toplevel.

## Interface
- WIDTH, 8, operand width in bits (legal 4..32)
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  asynchronous, active-low reset
- Run  input  1  active-low start button (asynchronous to Clk)
- ClearA_LoadB  input  1  active-low load button (asynchronous to Clk)
- SignedMode  input  1  1 = two's-complement multiply, 0 = unsigned; latched at run start
- S  input  WIDTH  switch operand: the value loaded into B, and the multiplicand at run start
- Aval  output  WIDTH  A register (upper product half)
- Bval  output  WIDTH  B register (lower product half / multiplier)
- X  output  1  sign/carry extension bit
- Busy  output  1  high in ADD/SHIFT
- Done  output  1  one-cycle pulse on the transition into HOLD

## Operation
- Run and ClearA_LoadB each pass through a 2-flop synchronizer before the FSM samples them (runL_s, loadL_s).
- States: IDLE, ADD, SHIFT, HOLD.
- IDLE, loadL_s=0:
  - A←0, X←0, B←S.
  - Load has priority over run; run is ignored while load is held.
- IDLE, loadL_s=1, runL_s=0: start the multiply.
  - M←S, mode←SignedMode, A←0, X←0, cnt←0.
  - B is kept, which enables chaining.
  - Go to ADD.
- ADD:
  - If B[0]=1, add A + M, or A − M on the last iteration (cnt=WIDTH−1) in signed mode. The (WIDTH+1)-bit result goes to {X,A}.
    - Signed mode: operands sign-extended to WIDTH+1 bits.
    - Unsigned mode: operands zero-extended; the carry lands in X.
  - If B[0]=0, A is unchanged; X←A[WIDTH−1] in signed mode, X←0 in unsigned mode.
  - Go to SHIFT.
- SHIFT:
  - A←{X, A[WIDTH−1:1]}, B←{A[0], B[WIDTH−1:1]}.
  - X is kept in signed mode and cleared in unsigned mode.
  - cnt←cnt+1.
  - If cnt was WIDTH−1, go to HOLD; otherwise go to ADD.
- HOLD:
  - Registers are frozen.
  - Stay until runL_s=1, then go to IDLE. One button press gives exactly one multiply.
- ClearA_LoadB, S and SignedMode are ignored in ADD, SHIFT and HOLD. S is used only through M, captured at start.
- Arithmetic widths:
  - Add/subtract is done at WIDTH+1 bits; overflow beyond that is discarded.
  - cnt is $clog2(WIDTH) bits wide, clamped to at least 1.

## Timing
- Reset (async, active-low) values:
  - A=0, B=0, X=0, M=0, cnt=0, mode=0.
  - State IDLE, Busy=0, Done=0.
  - Both synchronizer chains preset to 1 (buttons released).
- A reset in any state, including mid-multiply, aborts immediately. Operation resumes from IDLE on the first edge after release.
- Input latency: a button edge is seen by the FSM 2 cycles after it arrives; a 1-cycle-wide low pulse is enough.
- Busy rises the cycle after start and stays high for exactly 2·WIDTH cycles.
- Done pulses high for 1 cycle, coincident with the first HOLD cycle, when Aval/Bval already hold the final product.
- Outputs are registered: Aval, Bval and X change only on Clk rising edges.
- If both buttons are low in IDLE, a load occurs every cycle. The multiply starts 2 cycles after ClearA_LoadB is released, if Run is still low.
- If Run is held low through completion, the block stays in HOLD with no retrigger.

## Structure
- Package mult_pkg: state_t enum (IDLE, ADD, SHIFT, HOLD) and the SYNC_STAGES=2 constant.
- Sub-module sync_2ff (single-bit, preset-to-1 synchronizer), instantiated once for Run and once for ClearA_LoadB.
- The FSM and datapath live together in shift_add_mult_n.

## Test plan
- WIDTH=8, signed: load 7, S=59, pulse Run → after 16 busy cycles, Done pulses; A=0x01, B=0x9D.
- WIDTH=8, signed: the three sign combinations 7·−59, −7·59, −7·−59 → A:B=0xFE63, 0xFE63, 0x019D.
- WIDTH=8, chained signed: load −2, then four runs with S=−2 → A:B=0xFFE0 (−32). Done pulses exactly once per run while Run is held.
- WIDTH=8, unsigned: 255·255 → A=0xFE, B=0x01, X=0. Signed −128·−128 → A=0x40, B=0x00.
- WIDTH=16, signed: 300·−200 → A=0xFFFF, B=0x15A0 after 32 busy cycles. WIDTH=4, signed: −8·−8 → A=0x4, B=0x0.
- Reset asserted at cycle 5 of a run → A=B=X=0, Busy=0 immediately. ClearA_LoadB pulsed mid-run → no effect on registers.
